diode_receiver: RTL

Receive-side endpoint for the data diode. It drains the diode's output FIFO unconditionally, so the diode can never overflow, and re-buffers words for a downstream consumer that may stall. Its upstream handshake (in_ready) depends only on reset, never on downstream state, so no covert channel exists back through the diode. When the local buffer cannot take a word, the word is dropped and counted on the receive side only.

---
 rtl/diode_pkg.sv | 18 +
 rtl/diode_rx_buffer.sv | 69 ++++++
 rtl/diode_receiver.sv | 80 ++++++++
 3 files changed

// File: rtl/diode_pkg.sv
// Constants shared by both ends of the data diode, plus a saturating-increment helper.
package diode_pkg;

  localparam int DEFAULT_RATE       = 1;
  localparam int DEFAULT_DEPTH_BITS = 4;

  // Increments value, holding at the all-ones value of the given width.
  function automatic logic [31:0] saturating_inc(input logic [31:0] value, input int unsigned width);
    logic [32:0] max_v;
    max_v = (33'd1 << width) - 33'd1;
    if ({1'b0, value} >= max_v) begin
      saturating_inc = value;
    end else begin
      saturating_inc = value + 32'd1;
    end
  endfunction

endpackage

// File: rtl/diode_rx_buffer.sv
// Receive-side ring buffer with first-word fall-through read.
// A push is accepted when full provided a pop happens in the same cycle.
module diode_rx_buffer
  import diode_pkg::*;
#(
  parameter int DEPTH_BITS = DEFAULT_DEPTH_BITS,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [WIDTH-1:0]      rd_data,
  output logic [DEPTH_BITS:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [DEPTH_BITS:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS:0] rd_ptr_q, rd_ptr_d;
  logic                pop_ok_s;
  logic                push_ok_s;

  // Status flags and pointer advance; the extra MSB separates full from empty.
  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[DEPTH_BITS] != rd_ptr_q[DEPTH_BITS]) &&
                (wr_ptr_q[DEPTH_BITS-1:0] == rd_ptr_q[DEPTH_BITS-1:0]);
    level     = wr_ptr_q - rd_ptr_q;
    rd_data   = mem_q[rd_ptr_q[DEPTH_BITS-1:0]];
    pop_ok_s  = pop && !empty;
    push_ok_s = push && (!full || pop_ok_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + (DEPTH_BITS+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + (DEPTH_BITS+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is intentionally not reset; it is only read while non-empty.
  always_ff @(posedge clk) begin
    if (push_ok_s && !rst) begin
      mem_q[wr_ptr_q[DEPTH_BITS-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/diode_receiver.sv
// Data-diode receive endpoint: drains the diode unconditionally, re-buffers for a
// stalling consumer, and counts words that could not be buffered.
module diode_receiver
  import diode_pkg::*;
#(
  parameter int DEPTH_BITS = DEFAULT_DEPTH_BITS,
  parameter int WIDTH      = 8,
  parameter int DROP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready,
  output logic [DEPTH_BITS:0]   level,
  output logic [DROP_WIDTH-1:0] drop_count,
  output logic                  dropped
);

  logic                  in_ready_q, in_ready_d;
  logic [DROP_WIDTH-1:0] drop_count_q, drop_count_d;
  logic                  dropped_q, dropped_d;
  logic                  accept_s, pop_s, push_s, drop_s;
  logic                  full_s, empty_s;

  diode_rx_buffer #(
    .DEPTH_BITS (DEPTH_BITS),
    .WIDTH      (WIDTH)
  ) u_buffer (
    .clk     (clk),
    .rst     (rst),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data (in_data),
    .rd_data (out_data),
    .level   (level),
    .full    (full_s),
    .empty   (empty_s)
  );

  // in_ready depends on reset alone so nothing downstream can signal back upstream.
  always_comb begin
    in_ready_d   = 1'b1;
    accept_s     = in_valid && in_ready_q;
    pop_s        = !empty_s && out_ready;
    push_s       = accept_s && (!full_s || pop_s);
    drop_s       = accept_s && full_s && !pop_s;
    drop_count_d = drop_count_q;
    dropped_d    = dropped_q;
    if (drop_s) begin
      drop_count_d = DROP_WIDTH'(saturating_inc(32'(drop_count_q), DROP_WIDTH));
      dropped_d    = 1'b1;
    end else begin
      drop_count_d = drop_count_q;
      dropped_d    = dropped_q;
    end
  end

  // Ready and drop-accounting registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q   <= 1'b0;
      drop_count_q <= '0;
      dropped_q    <= 1'b0;
    end else begin
      in_ready_q   <= in_ready_d;
      drop_count_q <= drop_count_d;
      dropped_q    <= dropped_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = !empty_s;
  assign drop_count = drop_count_q;
  assign dropped    = dropped_q;

endmodule
